// File: rtl/lbp_engine_param.sv
// Streaming 3x3 local-binary-pattern engine over a W x H frame held in host memory.
// A sliding window reuses two columns per interior pixel, so only the new column is fetched.
module lbp_engine_param #(
   parameter int unsigned IMG_W = 128,
   parameter int unsigned IMG_H = 128,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   input  logic [DW-1:0] lbp_thr,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [DW-1:0] gray_data,
   output logic          lbp_valid,
   output logic [AW-1:0] lbp_addr,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);
   localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

   typedef enum logic [2:0] {StIdle, StScan, StReq, StWrite, StDone} state_e;

   state_e        state_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [AW-1:0] pix_addr_q;
   logic [DW-1:0] thr_q;
   logic [3:0]    cnt_q;
   logic          fill_q;
   // Read pipeline: slot of the request in flight, then slot whose data is on gray_data.
   logic          p1_vld_q, p2_vld_q;
   logic [3:0]    p1_slot_q, p2_slot_q;
   logic [DW-1:0] win_q [3][3];  // [col][row]
   logic [DW-1:0] win_n [3][3];

   logic          x_last, border, last_pix, scan_fill;
   logic          iss_fill;
   logic [3:0]    iss_k, iss_slot;
   logic [DW:0]   ref_lvl;
   logic [7:0]    code;

   // Request k -> {col,row}; FILL walks columns left to right, rows top to bottom.
   function automatic logic [3:0] req_slot(input logic fill, input logic [3:0] k);
      if (fill) return {2'(k / 4'd3), 2'(k % 4'd3)};
      return {2'd2, k[1:0]};
   endfunction

   function automatic logic [AW-1:0] req_addr(input logic [AW-1:0] base, input logic [3:0] slot);
      return base + AW'(slot[3:2]) + AW'(slot[1:0]) * AW'(IMG_W) - AW'(IMG_W + 1);
   endfunction

   // Compare at DW+1 bits so centre+threshold never wraps.
   function automatic logic ge(input logic [DW-1:0] g, input logic [DW:0] lvl);
      return {1'b0, g} >= lvl;
   endfunction

   assign x_last    = (x_q == XLast);
   assign border    = (x_q == '0) || x_last || (y_q == '0) || (y_q == YLast);
   assign last_pix  = x_last && (y_q == YLast);
   assign scan_fill = (x_q == XW'(1));
   assign iss_fill  = (state_q == StScan) ? scan_fill : fill_q;
   assign iss_k     = (state_q == StScan) ? 4'd0 : cnt_q;
   assign iss_slot  = req_slot(iss_fill, iss_k);

   always_comb begin
      win_n = win_q;
      if (p2_vld_q) win_n[p2_slot_q[3:2]][p2_slot_q[1:0]] = gray_data;
      ref_lvl = {1'b0, win_n[1][1]} + {1'b0, thr_q};
      code = {ge(win_n[2][2], ref_lvl), ge(win_n[1][2], ref_lvl), ge(win_n[0][2], ref_lvl),
              ge(win_n[2][1], ref_lvl), ge(win_n[0][1], ref_lvl),
              ge(win_n[2][0], ref_lvl), ge(win_n[1][0], ref_lvl), ge(win_n[0][0], ref_lvl)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         pix_addr_q <= '0;
         thr_q      <= '0;
         cnt_q      <= '0;
         fill_q     <= 1'b0;
         p1_vld_q   <= 1'b0;
         p2_vld_q   <= 1'b0;
         p1_slot_q  <= '0;
         p2_slot_q  <= '0;
         gray_req   <= 1'b0;
         gray_addr  <= '0;
         lbp_valid  <= 1'b0;
         lbp_addr   <= '0;
         lbp_data   <= '0;
         finish     <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) win_q[c][r] <= '0;
         end
      end else begin
         gray_req  <= 1'b0;
         lbp_valid <= 1'b0;
         p1_vld_q  <= 1'b0;
         p2_vld_q  <= p1_vld_q;
         p2_slot_q <= p1_slot_q;
         win_q     <= win_n;
         unique case (state_q)
            StIdle: begin
               if (gray_ready) begin
                  thr_q      <= lbp_thr;
                  x_q        <= '0;
                  y_q        <= '0;
                  pix_addr_q <= '0;
                  state_q    <= StScan;
               end
            end
            StScan: begin
               if (border) begin
                  lbp_valid  <= 1'b1;
                  lbp_addr   <= pix_addr_q;
                  lbp_data   <= '0;
                  pix_addr_q <= pix_addr_q + AW'(1);
                  if (x_last) begin
                     x_q <= '0;
                     y_q <= y_q + YW'(1);
                  end else begin
                     x_q <= x_q + XW'(1);
                  end
                  if (last_pix) state_q <= StDone;
               end else begin
                  fill_q <= scan_fill;
                  if (!scan_fill) begin
                     for (int c = 0; c < 2; c++) begin
                        for (int r = 0; r < 3; r++) win_q[c][r] <= win_q[c+1][r];
                     end
                  end
                  gray_req  <= 1'b1;
                  gray_addr <= req_addr(pix_addr_q, iss_slot);
                  p1_vld_q  <= 1'b1;
                  p1_slot_q <= iss_slot;
                  cnt_q     <= 4'd1;
                  state_q   <= StReq;
               end
            end
            StReq: begin
               if (cnt_q == (fill_q ? 4'd9 : 4'd3)) begin
                  state_q <= StWrite;
               end else begin
                  gray_req  <= 1'b1;
                  gray_addr <= req_addr(pix_addr_q, iss_slot);
                  p1_vld_q  <= 1'b1;
                  p1_slot_q <= iss_slot;
                  cnt_q     <= cnt_q + 4'd1;
               end
            end
            StWrite: begin
               // Last fetched pixel arrives this cycle; code uses the bypassed window.
               lbp_valid  <= 1'b1;
               lbp_addr   <= pix_addr_q;
               lbp_data   <= code;
               x_q        <= x_q + XW'(1);
               pix_addr_q <= pix_addr_q + AW'(1);
               state_q    <= StScan;
            end
            StDone: begin
               finish <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp_engine_param.sv
// Directed checks of the LBP engine: a 4x4 instance with hand-computed codes and a 24x16
// instance against a small golden model, including mid-frame reset and restart.
module tb_lbp_engine_param;

   localparam int WA = 4, HA = 4, AWA = 4;
   localparam int WB = 24, HB = 16, AWB = 9;
   localparam int LAT_A = 46;
   localparam int LAT_B = 2 + (2*WB + 2*HB - 4) + (HB - 2) * (11 + (WB - 3) * 5);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_a, ready_a, req_a, valid_a, fin_a;
   logic [7:0]     thr_a, gdata_a, code_a;
   logic [AWA-1:0] gaddr_a, laddr_a;
   logic           rst_b, ready_b, req_b, valid_b, fin_b;
   logic [7:0]     thr_b, gdata_b, code_b;
   logic [AWB-1:0] gaddr_b, laddr_b;

   logic [7:0] mem_a [WA*HA];
   logic [7:0] exp_a [WA*HA];
   logic [7:0] mem_b [WB*HB];

   int checks = 0, errors = 0;
   int exp_next_a, nwr_a, exp_next_b, nwr_b;
   logic [7:0] gthr_b;

   lbp_engine_param #(.IMG_W(WA), .IMG_H(HA), .DW(8), .AW(AWA)) dut_a (
      .clk(clk), .reset(rst_a), .gray_ready(ready_a), .lbp_thr(thr_a),
      .gray_req(req_a), .gray_addr(gaddr_a), .gray_data(gdata_a),
      .lbp_valid(valid_a), .lbp_addr(laddr_a), .lbp_data(code_a), .finish(fin_a)
   );

   lbp_engine_param #(.IMG_W(WB), .IMG_H(HB), .DW(8), .AW(AWB)) dut_b (
      .clk(clk), .reset(rst_b), .gray_ready(ready_b), .lbp_thr(thr_b),
      .gray_req(req_b), .gray_addr(gaddr_b), .gray_data(gdata_b),
      .lbp_valid(valid_b), .lbp_addr(laddr_b), .lbp_data(code_b), .finish(fin_b)
   );

   // Synchronous-read frame memories: data appears the cycle after the request.
   always @(posedge clk) if (req_a) gdata_a <= mem_a[gaddr_a];
   always @(posedge clk) if (req_b) gdata_b <= mem_b[gaddr_b];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gold_b(input int a, input logic [7:0] thr);
      int x, y, k;
      logic [8:0] lvl;
      logic [7:0] r;
      x = a % WB;
      y = a / WB;
      r = 8'h00;
      if (a >= WB*HB || x == 0 || x == WB-1 || y == 0 || y == HB-1) return 8'h00;
      lvl = {1'b0, mem_b[a]} + {1'b0, thr};
      k = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
               r[k] = ({1'b0, mem_b[(y+dy)*WB + x + dx]} >= lvl);
               k++;
            end
         end
      end
      return r;
   endfunction

   task automatic cycle_a();
      @(posedge clk); #1;
      if (valid_a) begin
         check("wr_addr_a", 32'(laddr_a), exp_next_a);
         check("code_a", code_a, exp_a[laddr_a]);
         exp_next_a++;
         nwr_a++;
      end
      if (fin_a) check("done_quiet_a", {30'b0, req_a, valid_a}, 0);
   endtask

   task automatic cycle_b();
      @(posedge clk); #1;
      if (valid_b) begin
         check("wr_addr_b", 32'(laddr_b), exp_next_b);
         check("code_b", code_b, gold_b(int'(laddr_b), gthr_b));
         exp_next_b++;
         nwr_b++;
      end
      if (fin_b) check("done_quiet_b", {30'b0, req_b, valid_b}, 0);
   endtask

   task automatic reset_a();
      @(negedge clk); rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic set_exp_a(input logic [7:0] inner);
      for (int i = 0; i < WA*HA; i++) exp_a[i] = 8'h00;
      exp_a[5] = inner; exp_a[6] = inner; exp_a[9] = inner; exp_a[10] = inner;
   endtask

   task automatic run_a(input logic [7:0] thr, input string tag);
      int n;
      @(negedge clk);
      thr_a = thr; ready_a = 1'b1; exp_next_a = 0; nwr_a = 0; n = 0;
      do begin
         cycle_a();
         ready_a = 1'b0;
         n++;
      end while (!fin_a && n < 500);
      check({tag, "_latency"}, n, LAT_A);
      check({tag, "_writes"}, nwr_a, WA*HA);
   endtask

   task automatic run_b(input logic [7:0] thr, input string tag);
      int n;
      @(negedge clk);
      thr_b = thr; gthr_b = thr; ready_b = 1'b1; exp_next_b = 0; nwr_b = 0; n = 0;
      do begin
         cycle_b();
         ready_b = 1'b0;
         n++;
      end while (!fin_b && n < LAT_B + 100);
      check({tag, "_latency"}, n, LAT_B);
      check({tag, "_writes"}, nwr_b, WB*HB);
   endtask

   initial begin
      int n0;
      rst_a = 1'b1; ready_a = 1'b0; thr_a = 8'h00;
      rst_b = 1'b1; ready_b = 1'b0; thr_b = 8'h00; gthr_b = 8'h00;
      exp_next_a = 0; nwr_a = 0; exp_next_b = 0; nwr_b = 0;
      for (int i = 0; i < WA*HA; i++) mem_a[i] = 8'h50;
      for (int i = 0; i < WB*HB; i++) mem_b[i] = 8'($urandom_range(0, 255));
      repeat (3) @(posedge clk);
      #1;
      check("rst_gray_req", req_a, 1'b0);
      check("rst_gray_addr", gaddr_a, 0);
      check("rst_lbp_valid", valid_a, 1'b0);
      check("rst_lbp_addr", laddr_a, 0);
      check("rst_lbp_data", code_a, 8'h00);
      check("rst_finish", fin_a, 1'b0);
      @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
      // Idle without gray_ready: nothing moves
      repeat (5) cycle_a();
      check("idle_no_req", {30'b0, req_a, valid_a}, 0);
      check("idle_no_finish", fin_a, 1'b0);

      // Flat 0x50, thr 0: every interior neighbour ties -> all ones
      set_exp_a(8'hFF);
      run_a(8'h00, "flat_thr0");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); ready_a = i[0];
         cycle_a();
         check("finish_held", fin_a, 1'b1);
      end
      ready_a = 1'b0;

      // Same image, thr 1: no neighbour reaches centre+1
      reset_a();
      set_exp_a(8'h00);
      run_a(8'h01, "flat_thr1");

      // Ramp pixel = addr: only the lower row plus right neighbour are larger
      reset_a();
      for (int i = 0; i < WA*HA; i++) mem_a[i] = 8'(i);
      set_exp_a(8'hF0);
      run_a(8'h00, "ramp");

      // Overflow: 0xFF + 1 needs 9 bits, so 0xFF neighbours fail
      reset_a();
      for (int i = 0; i < WA*HA; i++) mem_a[i] = 8'hFF;
      set_exp_a(8'h00);
      run_a(8'h01, "ovf_ff");

      // Centre 0x10 + 0xEF = 0xFF: all 0xFF neighbours pass; other centres overflow
      reset_a();
      mem_a[5] = 8'h10;
      set_exp_a(8'h00);
      exp_a[5] = 8'hFF;
      run_a(8'hEF, "ovf_edge");

      // Larger frame: abort mid-frame, confirm silence, restart and compare to golden
      @(negedge clk); thr_b = 8'h00; gthr_b = 8'h00; ready_b = 1'b1;
      exp_next_b = 0; nwr_b = 0;
      for (int i = 0; i < 300; i++) begin
         cycle_b();
         ready_b = 1'b0;
      end
      check("b_partial_wrote", nwr_b > 0, 1'b1);
      @(negedge clk); rst_b = 1'b1;
      @(posedge clk); #1;
      check("b_abort_valid", valid_b, 1'b0);
      check("b_abort_req", req_b, 1'b0);
      @(negedge clk); rst_b = 1'b0;
      n0 = nwr_b;
      repeat (60) cycle_b();
      check("b_quiet_after_reset", nwr_b, n0);
      check("b_no_finish_idle", fin_b, 1'b0);
      run_b(8'h00, "b_restart");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); ready_b = ~i[0];
         cycle_b();
         check("b_finish_held", fin_b, 1'b1);
      end
      ready_b = 1'b0;

      // New random image with a nonzero threshold
      @(negedge clk); rst_b = 1'b1;
      for (int i = 0; i < WB*HB; i++) mem_b[i] = 8'($urandom_range(0, 255));
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      run_b(8'h03, "b_thr3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
